// File: rtl/fft_clk_pkg.sv
// Shared constants, pointer-width helper and DIV range guard for the FFT rate bridge.
`define FFT_DIV_CHECK(div_val) \
  if ((div_val) < 2 || (div_val) > 16) begin : g_bad_div \
    $error("fft_rate_bridge: DIV must be in 2..16"); \
  end

package fft_clk_pkg;
  localparam int FFT_DIV_DEFAULT        = 5;
  localparam int FFT_DATA_W             = 32;
  localparam int FFT_FIFO_DEPTH_DEFAULT = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fft_bridge_fifo.sv
// Small synchronous FIFO; the extra pointer bit separates full from empty.
module fft_bridge_fifo
  import fft_clk_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int DEPTH  = FFT_FIFO_DEPTH_DEFAULT
) (
  input  logic                    hclkin,
  input  logic                    resetn,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);
  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("fft_bridge_fifo: DEPTH must be a power of two >= 2");
  end

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointers alone decide what is valid.
  always_ff @(posedge hclkin) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fft_rate_bridge.sv
// Fast-rate ready/valid to 1/DIV clock-enable rate adapter with calib phase slip.
module fft_rate_bridge
  import fft_clk_pkg::*;
#(
  parameter int DIV        = FFT_DIV_DEFAULT,
  parameter int DATA_W     = FFT_DATA_W,
  parameter int FIFO_DEPTH = FFT_FIFO_DEPTH_DEFAULT
) (
  input  logic                        hclkin,
  input  logic                        resetn,
  input  logic                        calib,
  input  logic [DATA_W-1:0]           s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  output logic                        ce,
  output logic                        underrun,
  output logic [clog2(FIFO_DEPTH):0]  level
);
  localparam int CNT_W = clog2(DIV);
  localparam int LVL_W = clog2(FIFO_DEPTH) + 1;

  `FFT_DIV_CHECK(DIV)

  logic [CNT_W-1:0]  cnt;
  logic              calib_q;
  logic              hold;
  logic              wrap;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [LVL_W-1:0]  level_nxt;

  assign hold = calib & ~calib_q;
  assign wrap = (cnt == CNT_W'(DIV - 1)) && !hold;
  assign push = s_valid && s_ready && !fifo_full;
  // Empty is sampled before any same-edge push, so a word arriving on a wrap waits a period.
  assign pop  = wrap && !fifo_empty;

  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + LVL_W'(1);
    else if (pop && !push) level_nxt = level - LVL_W'(1);
  end

  fft_bridge_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .hclkin (hclkin),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (s_data),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      calib_q <= 1'b0;
    end else begin
      calib_q <= calib;
      if (hold)      cnt <= cnt;
      else if (wrap) cnt <= '0;
      else           cnt <= cnt + 1'b1;
    end
  end

  // s_ready tracks the post-update occupancy so it always equals !full.
  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      s_ready  <= 1'b0;
      ce       <= 1'b0;
      underrun <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
    end else begin
      s_ready  <= (level_nxt != LVL_W'(FIFO_DEPTH));
      ce       <= wrap;
      underrun <= wrap && fifo_empty;
      if (wrap) begin
        m_valid <= !fifo_empty;
        if (!fifo_empty) m_data <= fifo_rdata;
      end
    end
  end
endmodule

// File: tb/tb_fft_rate_bridge.sv
// Scoreboard bench for fft_rate_bridge at DIV=5, DATA_W=32, FIFO_DEPTH=4.
module tb_fft_rate_bridge;
  localparam int DIV    = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              hclkin  = 1'b0;
  logic              resetn  = 1'b0;
  logic              calib   = 1'b0;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data  = '0;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              ce;
  logic              underrun;
  logic [2:0]        level;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                edge_n;
  } exp_t;
  exp_t sb[$];

  fft_rate_bridge #(
    .DIV        (DIV),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .hclkin   (hclkin),
    .resetn   (resetn),
    .calib    (calib),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .ce       (ce),
    .underrun (underrun),
    .level    (level)
  );

  always #5 hclkin = ~hclkin;
  always @(posedge hclkin) cyc <= cyc + 1;

  task automatic tick();
    @(posedge hclkin);
    #1;
  endtask

  task automatic wait_ce(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ce === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    int waited;
    waited = 0;
    while (s_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL push_ready: s_ready=%b, required 1 within 20 cycles", s_ready);
    end
    s_data  = d;
    s_valid = 1'b1;
    sb.push_back('{d, cyc + 1});
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({ce, m_valid, underrun, s_ready} !== 4'b0 || m_data !== '0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ce=%b m_valid=%b underrun=%b s_ready=%b m_data=%h level=%0d, required all 0",
               ce, m_valid, underrun, s_ready, m_data, level);
    end
    resetn = 1'b1;
    for (int e = 1; e <= DIV; e++) begin
      tick();
      if (e == 1) begin
        n_checks++;
        if (s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_s_ready: s_ready=%b after edge 1, required 1", s_ready);
        end
      end
      if (e == DIV - 1) begin
        n_checks++;
        if (ce !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_early_ce: ce=%b after edge %0d, required 0", ce, e);
        end
      end
    end
    n_checks++;
    if (ce !== 1'b1 || underrun !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_ce: ce=%b underrun=%b m_valid=%b after edge 5, required 1 1 0",
               ce, underrun, m_valid);
    end
  endtask

  task automatic test_stream();
    bit   ok;
    exp_t e;
    e = '{'0, 0};
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    n_checks++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL stream_level_peak: level=%0d, required 3", level);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        wait_ce(ok);
        n_checks++;
        if (!ok) begin
          n_fail++;
          $display("FAIL stream_ce_timeout: ce=0 for 40 cycles, required 1");
        end
      end else begin
        for (int j = 0; j < DIV - 1; j++) begin
          tick();
          n_checks++;
          if (ce !== 1'b0 || m_data !== e.data) begin
            n_fail++;
            $display("FAIL stream_hold: ce=%b m_data=%h, required 0 %h", ce, m_data, e.data);
          end
        end
        tick();
        n_checks++;
        if (ce !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_period: ce=%b after %0d cycles, required 1", ce, DIV);
        end
      end
      if (sb.size() > 0) e = sb.pop_front();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== e.data) begin
        n_fail++;
        $display("FAIL stream_data: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, e.data);
      end
    end
  endtask

  task automatic test_underrun();
    bit ok;
    for (int p = 0; p < 2; p++) begin
      wait_ce(ok);
      n_checks++;
      if (!ok || underrun !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h33) begin
        n_fail++;
        $display("FAIL underrun_pulse: ce_seen=%b underrun=%b m_valid=%b m_data=%h, required 1 1 0 00000033",
                 ok, underrun, m_valid, m_data);
      end
      tick();
      n_checks++;
      if (underrun !== 1'b0) begin
        n_fail++;
        $display("FAIL underrun_width: underrun=%b one cycle after ce, required 0", underrun);
      end
    end
  endtask

  task automatic test_refill();
    bit   ok;
    exp_t e;
    e = '{'0, 0};
    push_word(32'hAA);
    wait_ce(ok);
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || m_valid !== 1'b1 || m_data !== e.data || underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_data: ce_seen=%b m_valid=%b m_data=%h underrun=%b, required 1 1 %h 0",
               ok, m_valid, m_data, underrun, e.data);
    end
  endtask

  task automatic test_full();
    int   n_acc;
    int   max_lvl;
    bit   saw_full;
    exp_t e;
    n_acc    = 0;
    max_lvl  = 0;
    saw_full = 1'b0;
    resetn   = 1'b0;
    tick();
    tick();
    sb.delete();
    resetn = 1'b1;
    for (int i = 0; i < 80 && !(n_acc == 6 && sb.size() == 0); i++) begin
      if (ce === 1'b1) begin
        if (sb.size() > 0 && sb[0].edge_n < cyc) begin
          e = sb.pop_front();
          n_checks++;
          if (m_valid !== 1'b1 || m_data !== e.data) begin
            n_fail++;
            $display("FAIL full_data: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, e.data);
          end
        end else begin
          n_checks++;
          if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty_pop: m_valid=%b, required 0", m_valid);
          end
        end
      end
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (level == 3'd4) begin
        saw_full = 1'b1;
        n_checks++;
        if (s_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL full_ready: s_ready=%b at level 4, required 0", s_ready);
        end
      end
      if (n_acc < 6) begin
        s_valid = 1'b1;
        s_data  = 32'h101 + n_acc;
        if (s_ready === 1'b1) begin
          sb.push_back('{s_data, cyc + 1});
          n_acc++;
        end
      end else begin
        s_valid = 1'b0;
      end
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (n_acc != 6 || sb.size() != 0 || !saw_full || max_lvl != DEPTH) begin
      n_fail++;
      $display("FAIL full_summary: accepted=%0d left=%0d saw_full=%b max_level=%0d, required 6 0 1 4",
               n_acc, sb.size(), saw_full, max_lvl);
    end
  endtask

  task automatic test_calib();
    bit ok;
    int a, b, c;
    wait_ce(ok);
    a = cyc;
    tick();
    tick();
    calib = 1'b1;
    tick();
    calib = 1'b0;
    wait_ce(ok);
    b = cyc;
    n_checks++;
    if (!ok || b - a != DIV + 1) begin
      n_fail++;
      $display("FAIL calib_slip: period=%0d, required %0d", b - a, DIV + 1);
    end
    wait_ce(ok);
    c = cyc;
    n_checks++;
    if (!ok || c - b != DIV) begin
      n_fail++;
      $display("FAIL calib_recover: period=%0d, required %0d", c - b, DIV);
    end
  endtask

  task automatic test_calib_held();
    bit ok;
    int a, last, n;
    wait_ce(ok);
    a     = cyc;
    last  = a;
    n     = 0;
    calib = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ce === 1'b1) begin
        n++;
        last = cyc;
      end
    end
    calib = 1'b0;
    wait_ce(ok);
    n++;
    last = cyc;
    n_checks++;
    if (!ok || (last - a) - DIV * n != 1) begin
      n_fail++;
      $display("FAIL calib_held: slip=%0d cycles over %0d periods, required 1", (last - a) - DIV * n, n);
    end
  endtask

  task automatic test_mid_reset();
    bit   ok;
    exp_t e;
    e = '{'0, 0};
    push_word(32'h51);
    wait_ce(ok);
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || m_valid !== 1'b1 || m_data !== e.data) begin
      n_fail++;
      $display("FAIL midrst_pre_data: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, e.data);
    end
    push_word(32'h52);
    push_word(32'h53);
    push_word(32'h54);
    n_checks++;
    if (level !== 3'd3 || m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_state: level=%0d m_valid=%b, required 3 1", level, m_valid);
    end
    #3 resetn = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if ({ce, m_valid, underrun, s_ready} !== 4'b0 || m_data !== '0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_async: ce=%b m_valid=%b underrun=%b s_ready=%b m_data=%h level=%0d, required all 0",
               ce, m_valid, underrun, s_ready, m_data, level);
    end
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 1; k <= DIV; k++) begin
      tick();
      if (k == 1) begin
        n_checks++;
        if (s_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_s_ready: s_ready=%b after edge 1, required 1", s_ready);
        end
      end
      if (k == DIV - 1) begin
        n_checks++;
        if (ce !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_early_ce: ce=%b after edge %0d, required 0", ce, k);
        end
      end
    end
    n_checks++;
    if (ce !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_first_ce: ce=%b m_valid=%b m_data=%h underrun=%b, required 1 0 0 1",
               ce, m_valid, m_data, underrun);
    end
    push_word(32'h77);
    wait_ce(ok);
    if (sb.size() > 0) e = sb.pop_front();
    n_checks++;
    if (!ok || m_valid !== 1'b1 || m_data !== e.data) begin
      n_fail++;
      $display("FAIL midrst_new_data: m_valid=%b m_data=%h, required 1 %h", m_valid, m_data, e.data);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_refill();
    test_full();
    test_calib();
    test_calib_held();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded 200000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
